// File: rtl/m_fifo_param_pkg.sv
// Shared defaults for the parametrised FWFT FIFO: default word width, default
// depth exponent and the occupancy-count width rule.
package m_fifo_param_pkg;

    localparam int DEF_WIDTH  = 36;
    localparam int DEF_ADDR_W = 4;

    // Occupancy must represent 0..DEPTH inclusive, hence one bit beyond the address.
    function automatic int occ_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/m_fifo_param_if.sv
// One streaming link: data plus src_rdy (producer has a word) and dst_rdy
// (consumer takes it). A word transfers on any rising edge where both are high.
interface m_fifo_param_if #(
    parameter int WIDTH = 36
);
    logic [WIDTH-1:0] data;
    logic             src_rdy;
    logic             dst_rdy;

    modport master (output data, output src_rdy, input dst_rdy);
    modport slave  (input data, input src_rdy, output dst_rdy);
endinterface

// File: rtl/m_fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Kept apart from the control logic so the inferred memory style can be swapped.
module m_fifo_ram #(
    parameter int WIDTH  = 36,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/m_fifo_param.sv
// First-word-fall-through FIFO with occupancy/space counts and programmable
// almost-full/almost-empty flags. All DEPTH entries are usable.
module m_fifo_param
    import m_fifo_param_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int AFULL_LVL  = (1 << ADDR_W) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    m_fifo_param_if.slave               wr_if,
    m_fifo_param_if.master              rd_if,
    output logic [occ_w(ADDR_W)-1:0]    occupied,
    output logic [occ_w(ADDR_W)-1:0]    space,
    output logic                        almost_full,
    output logic                        almost_empty
);
    localparam int OCC_W = occ_w(ADDR_W);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [OCC_W-1:0] DEPTH_V  = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] AFULL_V  = OCC_W'(AFULL_LVL);
    localparam logic [OCC_W-1:0] AEMPTY_V = OCC_W'(AEMPTY_LVL);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              full, empty;
    logic              wr_fire, rd_fire;

    // Full and empty come from the counter, so pointer equality is never ambiguous.
    assign full    = (occ_q == DEPTH_V);
    assign empty   = (occ_q == '0);
    assign wr_fire = wr_if.src_rdy & ~full;
    assign rd_fire = rd_if.dst_rdy & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            if (wr_fire && !rd_fire) begin
                occ_d = occ_q + OCC_W'(1);
            end else if (rd_fire && !wr_fire) begin
                occ_d = occ_q - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    m_fifo_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (wr_fire & ~clear),
        .waddr (wr_ptr_q),
        .wdata (wr_if.data),
        .raddr (rd_ptr_q),
        .rdata (rd_if.data)
    );

    assign wr_if.dst_rdy = ~full;
    assign rd_if.src_rdy = ~empty;
    assign occupied      = occ_q;
    assign space         = DEPTH_V - occ_q;
    assign almost_full   = (occ_q >= AFULL_V);
    assign almost_empty  = (occ_q <= AEMPTY_V);
endmodule

// File: tb/tb_m_fifo_param.sv
// Directed bench for m_fifo_param: a 36x16 instance driven from a vector table
// and hand sequences, plus an 8x2 instance for the small-depth corner cases.
module tb_m_fifo_param;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;

  always #5 clock = ~clock;

  m_fifo_param_if #(.WIDTH(36)) a_in ();
  m_fifo_param_if #(.WIDTH(36)) a_out ();
  m_fifo_param_if #(.WIDTH(8))  b_in ();
  m_fifo_param_if #(.WIDTH(8))  b_out ();

  logic [4:0] a_occ, a_space;
  logic       a_af, a_ae;
  logic [1:0] b_occ, b_space;
  logic       b_af, b_ae;

  m_fifo_param dut_a (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .wr_if        (a_in),
    .rd_if        (a_out),
    .occupied     (a_occ),
    .space        (a_space),
    .almost_full  (a_af),
    .almost_empty (a_ae)
  );

  m_fifo_param #(.WIDTH(8), .ADDR_W(1)) dut_b (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .wr_if        (b_in),
    .rd_if        (b_out),
    .occupied     (b_occ),
    .space        (b_space),
    .almost_full  (b_af),
    .almost_empty (b_ae)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        src;
    logic [35:0] din;
    logic        dst;
    logic        exp_src_o;
    logic        exp_dst_o;
    int          exp_occ;
    logic [35:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Depth 16, almost_full at >=14, almost_empty at <=2.
  task automatic chk_a(input string tag, input logic e_src, input logic e_dst,
                       input int e_occ, input logic chk_dout, input logic [35:0] e_dout);
    chk({tag, ".src_rdy_o"}, 64'(a_out.src_rdy), 64'(e_src));
    chk({tag, ".dst_rdy_o"}, 64'(a_in.dst_rdy), 64'(e_dst));
    chk({tag, ".occupied"}, 64'(a_occ), 64'(e_occ));
    chk({tag, ".space"}, 64'(a_space), 64'(16 - e_occ));
    chk({tag, ".almost_full"}, 64'(a_af), 64'(e_occ >= 14));
    chk({tag, ".almost_empty"}, 64'(a_ae), 64'(e_occ <= 2));
    if (chk_dout) chk({tag, ".dataout"}, 64'(a_out.data), 64'(e_dout));
  endtask

  // Depth 2 with default levels: AFULL_LVL=0 and AEMPTY_LVL=2, so both flags stay high.
  task automatic chk_b(input string tag, input logic e_src, input logic e_dst,
                       input int e_occ, input logic chk_dout, input logic [7:0] e_dout);
    chk({tag, ".src_rdy_o"}, 64'(b_out.src_rdy), 64'(e_src));
    chk({tag, ".dst_rdy_o"}, 64'(b_in.dst_rdy), 64'(e_dst));
    chk({tag, ".occupied"}, 64'(b_occ), 64'(e_occ));
    chk({tag, ".space"}, 64'(b_space), 64'(2 - e_occ));
    chk({tag, ".almost_full"}, 64'(b_af), 64'd1);
    chk({tag, ".almost_empty"}, 64'(b_ae), 64'd1);
    if (chk_dout) chk({tag, ".dataout"}, 64'(b_out.data), 64'(e_dout));
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic a_drive(input logic src, input logic [35:0] din, input logic dst);
    a_in.src_rdy  = src;
    a_in.data     = din;
    a_out.dst_rdy = dst;
  endtask

  task automatic b_drive(input logic src, input logic [7:0] din, input logic dst);
    b_in.src_rdy  = src;
    b_in.data     = din;
    b_out.dst_rdy = dst;
  endtask

  initial begin
    a_drive(1'b0, '0, 1'b0);
    b_drive(1'b0, '0, 1'b0);

    // Fill 16 with no reads, one ignored 17th write, then drain in order.
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b1, 36'(i + 1), 1'b0, 1'b1, (i < 15), i + 1, 36'd1});
    vecs.push_back('{1'b1, 36'h99, 1'b0, 1'b1, 1'b0, 16, 36'd1});
    for (int k = 1; k <= 16; k++)
      vecs.push_back('{1'b0, 36'h0, 1'b1, (k < 16), 1'b1, 16 - k, 36'(k + 1)});

    #12;
    reset = 1'b0;
    #1;
    chk_a("reset_a", 1'b0, 1'b1, 0, 1'b0, '0);
    chk_b("reset_b", 1'b0, 1'b1, 0, 1'b0, '0);
    @(negedge clock);
    @(posedge clock);
    #1;

    foreach (vecs[i]) begin
      a_drive(vecs[i].src, vecs[i].din, vecs[i].dst);
      tick();
      chk_a($sformatf("vec%0d", i), vecs[i].exp_src_o, vecs[i].exp_dst_o,
            vecs[i].exp_occ, vecs[i].exp_src_o, vecs[i].exp_dout);
    end

    // 40 words streamed at one per cycle: each appears one edge after its write.
    for (int i = 0; i < 40; i++) begin
      a_drive(1'b1, 36'h8_0000_0000 | 36'(i), 1'b1);
      tick();
      chk_a($sformatf("stream%0d", i), 1'b1, 1'b1, 1, 1'b1, 36'h8_0000_0000 | 36'(i));
    end
    a_drive(1'b0, '0, 1'b1);
    tick();
    chk_a("stream_end", 1'b0, 1'b1, 0, 1'b0, '0);

    // Read and write together while full: only the read takes effect.
    for (int i = 0; i < 16; i++) begin
      a_drive(1'b1, 36'h100 + 36'(i), 1'b0);
      tick();
    end
    chk_a("full_pre", 1'b1, 1'b0, 16, 1'b1, 36'h100);
    a_drive(1'b1, 36'h5A, 1'b1);
    tick();
    chk_a("full_rw", 1'b1, 1'b1, 15, 1'b1, 36'h101);
    a_drive(1'b0, '0, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_a("clear_full", 1'b0, 1'b1, 0, 1'b0, '0);

    // Clear at occupancy 9 beats a simultaneous read and write.
    for (int i = 0; i < 9; i++) begin
      a_drive(1'b1, 36'h200 + 36'(i), 1'b0);
      tick();
    end
    chk_a("fill9", 1'b1, 1'b1, 9, 1'b1, 36'h200);
    a_drive(1'b1, 36'hBAD, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_a("clear9", 1'b0, 1'b1, 0, 1'b0, '0);
    a_drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a($sformatf("post_clear%0d", i), 1'b0, 1'b1, 0, 1'b0, '0);
    end
    a_drive(1'b1, 36'hABC, 1'b0);
    tick();
    chk_a("post_clear_wr", 1'b1, 1'b1, 1, 1'b1, 36'hABC);
    a_drive(1'b0, '0, 1'b1);
    tick();
    chk_a("post_clear_rd", 1'b0, 1'b1, 0, 1'b0, '0);

    // Asynchronous reset between edges at occupancy 5.
    for (int i = 0; i < 5; i++) begin
      a_drive(1'b1, 36'h300 + 36'(i), 1'b0);
      tick();
    end
    chk_a("pre_reset", 1'b1, 1'b1, 5, 1'b1, 36'h300);
    #3;
    reset = 1'b1;
    #1;
    chk_a("async_reset", 1'b0, 1'b1, 0, 1'b0, '0);
    a_drive(1'b0, '0, 1'b0);
    #1;
    reset = 1'b0;
    tick();
    chk_a("after_reset", 1'b0, 1'b1, 0, 1'b0, '0);

    // Depth-2 instance: fill, overflow attempt, drain.
    b_drive(1'b1, 8'h11, 1'b0);
    tick();
    chk_b("b_wr1", 1'b1, 1'b1, 1, 1'b1, 8'h11);
    b_drive(1'b1, 8'h22, 1'b0);
    tick();
    chk_b("b_wr2", 1'b1, 1'b0, 2, 1'b1, 8'h11);
    b_drive(1'b1, 8'h33, 1'b0);
    tick();
    chk_b("b_wr3_ignored", 1'b1, 1'b0, 2, 1'b1, 8'h11);
    b_drive(1'b0, 8'h0, 1'b1);
    tick();
    chk_b("b_rd1", 1'b1, 1'b1, 1, 1'b1, 8'h22);
    tick();
    chk_b("b_rd2", 1'b0, 1'b1, 0, 1'b0, '0);

    for (int i = 0; i < 10; i++) begin
      b_drive(1'b1, 8'h40 + 8'(i), 1'b1);
      tick();
      chk_b($sformatf("b_stream%0d", i), 1'b1, 1'b1, 1, 1'b1, 8'h40 + 8'(i));
    end
    b_drive(1'b0, 8'h0, 1'b1);
    tick();
    chk_b("b_stream_end", 1'b0, 1'b1, 0, 1'b0, '0);

    b_drive(1'b1, 8'h71, 1'b0);
    tick();
    b_drive(1'b1, 8'h72, 1'b0);
    tick();
    chk_b("b_full", 1'b1, 1'b0, 2, 1'b1, 8'h71);
    b_drive(1'b1, 8'h73, 1'b1);
    tick();
    chk_b("b_full_rw", 1'b1, 1'b1, 1, 1'b1, 8'h72);
    b_drive(1'b0, 8'h0, 1'b1);
    tick();
    chk_b("b_final", 1'b0, 1'b1, 0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
